hub75_capture: RTL and testbench

Receive-side counterpart of the HUB75 panel driver: samples a HUB75 bus (sclk, lat, row address, two RGB lanes) from an external or looped-back driver and reconstructs the displayed image into a frame memory write port. One latched shift line is committed as two rows of pixels, the upper and the lower half. The block is used for loopback verification of the display path and for capturing frames from third-party controllers. It also drives the CPU-side write port of the dual-port frame memory with the same word format the CPU uses.

---
 rtl/hub75_capture.sv | 143 ++++++++++++++
 tb/tb_hub75_capture.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 bus receiver: rebuilds each latched shift line as an upper and a lower pixel row
// and writes them one word per cycle into the frame memory's CPU-side write port.
module hub75_capture #(
    parameter int unsigned WIDTH    = 96,
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned BPC      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk_in,
    input  logic        lat_in,
    input  logic        a_in,
    input  logic        b_in,
    input  logic        c_in,
    input  logic        d_in,
    input  logic        r0_in,
    input  logic        g0_in,
    input  logic        b0_in,
    input  logic        r1_in,
    input  logic        g1_in,
    input  logic        b1_in,
    input  logic        clr,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        len_err
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam int unsigned LW = 3 * WIDTH;
    localparam logic [XW-1:0] XLast  = XW'(WIDTH - 1);
    localparam logic [CW-1:0] CntLen = CW'(WIDTH);
    localparam logic [CW-1:0] CntMax = CW'(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StWrTop, StWrBot} state_e;

    state_e              state_q;
    logic [11:0]         sync1_q, sync2_q;
    logic                sclk_prev_q, lat_prev_q;
    logic [CW-1:0]       col_cnt_q;
    logic [XW-1:0]       x_q;
    logic [ROW_BITS-1:0] row_q;
    logic [LW-1:0]       top_line_q, bot_line_q, top_buf_q, bot_buf_q;

    logic                sclk_rise, lat_rise, accept;
    logic [3:0]          addr_s;
    logic [2:0]          rgb0_s, rgb1_s, px;
    logic [11:0]         wr_addr;
    logic [31:0]         wr_data;

    assign sclk_rise = sync2_q[11] & ~sclk_prev_q;
    assign lat_rise  = sync2_q[10] & ~lat_prev_q;
    assign addr_s    = sync2_q[9:6];
    assign rgb0_s    = sync2_q[5:3];
    assign rgb1_s    = sync2_q[2:0];
    assign accept    = lat_rise && (state_q == StIdle);

    always_comb begin
        wr_addr = 12'({(state_q == StWrBot), row_q}) * 12'(WIDTH) + 12'(x_q);
        px      = (state_q == StWrBot) ? bot_buf_q[3*int'(x_q) +: 3] : top_buf_q[3*int'(x_q) +: 3];
        wr_data = 32'({{BPC{px[2]}}, {BPC{px[1]}}, {BPC{px[0]}}});
    end

    // Column 0 of the line is the most recently shifted bit, matching panel order.
    always_ff @(posedge clk) begin
        if (sclk_rise) begin
            top_line_q <= {top_line_q[LW-4:0], rgb0_s};
            bot_line_q <= {bot_line_q[LW-4:0], rgb1_s};
        end
        if (accept) begin
            top_buf_q <= top_line_q;
            bot_buf_q <= bot_line_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sclk_prev_q <= 1'b0;
            lat_prev_q  <= 1'b0;
            col_cnt_q   <= '0;
            state_q     <= StIdle;
            x_q         <= '0;
            row_q       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            sync1_q     <= {sclk_in, lat_in, a_in, b_in, c_in, d_in,
                            r0_in, g0_in, b0_in, r1_in, g1_in, b1_in};
            sync2_q     <= sync1_q;
            sclk_prev_q <= sync2_q[11];
            lat_prev_q  <= sync2_q[10];

            if (sclk_rise && col_cnt_q != CntMax) col_cnt_q <= col_cnt_q + 1'b1;
            if (lat_rise) col_cnt_q <= '0;

            // Set beats clear when both happen in the same cycle.
            if (clr) begin
                overflow <= 1'b0;
                len_err  <= 1'b0;
            end
            if (lat_rise && state_q != StIdle) overflow <= 1'b1;
            if (accept && col_cnt_q != CntLen) len_err <= 1'b1;

            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= (state_q != StIdle);

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        row_q   <= addr_s[ROW_BITS-1:0];
                        x_q     <= '0;
                        state_q <= StWrTop;
                    end
                end
                StWrTop, StWrBot: begin
                    mem_we   <= 1'b1;
                    mem_addr <= wr_addr;
                    mem_data <= wr_data;
                    x_q      <= x_q + 1'b1;
                    if (x_q == XLast) begin
                        x_q     <= '0;
                        state_q <= (state_q == StWrTop) ? StWrBot : StIdle;
                        if (state_q == StWrBot && row_q == {ROW_BITS{1'b1}}) frame_done <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: a table of latched lines plus hand-written sequences
// for reset, full frame, overflow and reset during a commit.
module tb_hub75_capture;

    localparam int W = 96;

    logic        clk = 1'b0, rst = 1'b1;
    logic        sclk_in = 1'b0, lat_in = 1'b0;
    logic        a_in = 1'b0, b_in = 1'b0, c_in = 1'b0, d_in = 1'b0;
    logic        r0_in = 1'b0, g0_in = 1'b0, b0_in = 1'b0;
    logic        r1_in = 1'b0, g1_in = 1'b0, b1_in = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we, busy, frame_done, overflow, len_err;

    always #5 clk = ~clk;

    hub75_capture dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_in), .lat_in(lat_in),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .r0_in(r0_in), .g0_in(g0_in), .b0_in(b0_in),
        .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in),
        .clr(clr), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .frame_done(frame_done), .overflow(overflow), .len_err(len_err)
    );

    // Write log and event counters, sampled on the falling edge.
    int          wr_cnt = 0, busy_cnt = 0, fd_cnt = 0, fd_addr = -1;
    logic [11:0] log_addr [0:8191];
    logic [31:0] log_data [0:8191];

    always @(negedge clk) begin
        if (mem_we) begin
            log_addr[wr_cnt] <= mem_addr;
            log_data[wr_cnt] <= mem_data;
            wr_cnt           <= wr_cnt + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (frame_done) begin
            fd_cnt  <= fd_cnt + 1;
            fd_addr <= int'(mem_addr);
        end
    end

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int word(input logic [2:0] p);
        return int'({20'b0, {4{p[2]}}, {4{p[1]}}, {4{p[0]}}});
    endfunction

    task automatic shift_col(input logic [2:0] t, input logic [2:0] b);
        {r0_in, g0_in, b0_in} = t;
        {r1_in, g1_in, b1_in} = b;
        repeat (3) @(negedge clk);
        sclk_in = 1'b1;
        repeat (3) @(negedge clk);
        sclk_in = 1'b0;
    endtask

    task automatic shift_line(input int n, input logic [2:0] tf, input logic [2:0] tr,
                              input logic [2:0] bf, input logic [2:0] br);
        for (int i = 0; i < n; i++) shift_col((i == 0) ? tf : tr, (i == 0) ? bf : br);
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = 6'b0;
    endtask

    task automatic pulse_lat(input int row);
        logic [3:0] r;
        r = 4'(row);
        {a_in, b_in, c_in, d_in} = r;
        repeat (2) @(negedge clk);
        lat_in = 1'b1;
        repeat (3) @(negedge clk);
        lat_in = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        #1;
    endtask

    task automatic wait_commit();
        repeat (260) @(negedge clk);
        #1;
    endtask

    typedef struct {
        int         row;
        int         ncols;
        logic [2:0] tf, tr, bf, br;
        int         exp_len_err;
        int         exp_fd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base, bbase, fbase, addr_bad, data_bad, hits, idx, half, x;
        logic [2:0] p;

        vecs[0] = '{row: 5,  ncols: 96, tf: 3'b100, tr: 3'b000, bf: 3'b000, br: 3'b000,
                    exp_len_err: 0, exp_fd: 0};
        vecs[1] = '{row: 10, ncols: 96, tf: 3'b000, tr: 3'b001, bf: 3'b111, br: 3'b010,
                    exp_len_err: 0, exp_fd: 0};
        vecs[2] = '{row: 0,  ncols: 95, tf: 3'b110, tr: 3'b000, bf: 3'b000, br: 3'b011,
                    exp_len_err: 1, exp_fd: 0};
        vecs[3] = '{row: 15, ncols: 97, tf: 3'b111, tr: 3'b010, bf: 3'b111, br: 3'b101,
                    exp_len_err: 1, exp_fd: 1};
        vecs[4] = '{row: 15, ncols: 96, tf: 3'b011, tr: 3'b000, bf: 3'b000, br: 3'b100,
                    exp_len_err: 0, exp_fd: 1};

        // Reset with the bus toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sclk_in = ~sclk_in;
            lat_in  = ~lat_in;
        end
        #1;
        check("reset mem_we", int'(mem_we), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset mem_data", int'(mem_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset len_err", int'(len_err), 0);
        sclk_in = 1'b0;
        lat_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("writes during reset", wr_cnt, 0);

        // Table of single latched lines.
        for (int v = 0; v < 5; v++) begin
            pulse_clr();
            check("len_err after clr", int'(len_err), 0);
            base  = wr_cnt;
            bbase = busy_cnt;
            fbase = fd_cnt;
            shift_line(vecs[v].ncols, vecs[v].tf, vecs[v].tr, vecs[v].bf, vecs[v].br);
            pulse_lat(vecs[v].row);
            wait_commit();
            check("line writes", wr_cnt - base, 2 * W);
            check("line busy cycles", busy_cnt - bbase, 2 * W);
            check("line len_err", int'(len_err), vecs[v].exp_len_err);
            check("line frame_done", fd_cnt - fbase, vecs[v].exp_fd);
            if (vecs[v].exp_fd != 0) check("frame_done addr", fd_addr, 3071);
            addr_bad = 0;
            data_bad = 0;
            for (int j = 0; j < 2 * W; j++) begin
                half = j / W;
                x    = j % W;
                if (int'(log_addr[base + j]) != (vecs[v].row + 16 * half) * W + x) addr_bad++;
                idx = vecs[v].ncols - 1 - x;
                if (half == 0) p = (idx == 0) ? vecs[v].tf : vecs[v].tr;
                else           p = (idx == 0) ? vecs[v].bf : vecs[v].br;
                if (int'(log_data[base + j]) != word(p)) data_bad++;
            end
            check("line addresses", addr_bad, 0);
            if (vecs[v].ncols >= W) check("line data", data_bad, 0);
        end
        check("single row addr 575", int'(log_addr[95]), 575);
        check("single row data 575", int'(log_data[95]), 32'h0000_0F00);

        // Full frame with the lower green lane held high.
        pulse_clr();
        base  = wr_cnt;
        fbase = fd_cnt;
        for (int r = 0; r < 16; r++) begin
            shift_line(W, 3'b000, 3'b000, 3'b010, 3'b010);
            pulse_lat(r);
            wait_commit();
        end
        check("frame writes", wr_cnt - base, 16 * 2 * W);
        check("frame frame_done count", fd_cnt - fbase, 1);
        check("frame frame_done addr", fd_addr, 3071);
        addr_bad = 0;
        data_bad = 0;
        for (int i = 0; i < 16 * 2 * W; i++) begin
            half = (i % (2 * W)) / W;
            x    = i % W;
            if (int'(log_addr[base + i]) != (i / (2 * W) + 16 * half) * W + x) addr_bad++;
            if (int'(log_data[base + i]) != ((half == 1) ? 32'h0000_00F0 : 0)) data_bad++;
        end
        check("frame addresses", addr_bad, 0);
        check("frame data", data_bad, 0);
        check("frame len_err", int'(len_err), 0);

        // Second latch arrives while the first commit is still writing.
        base = wr_cnt;
        shift_line(W, 3'b000, 3'b001, 3'b000, 3'b000);
        pulse_lat(3);
        repeat (45) @(negedge clk);
        pulse_lat(7);
        wait_commit();
        check("overflow flag", int'(overflow), 1);
        check("overflow writes", wr_cnt - base, 2 * W);
        check("overflow first addr", int'(log_addr[base]), 3 * W);
        hits = 0;
        for (int i = base; i < wr_cnt; i++)
            if ((int'(log_addr[i]) / W) == 7 || (int'(log_addr[i]) / W) == 23) hits++;
        check("dropped row writes", hits, 0);
        check("overflow len_err", int'(len_err), 0);
        pulse_clr();
        check("overflow after clr", int'(overflow), 0);

        // Reset at the 40th write of a commit.
        shift_line(W, 3'b000, 3'b000, 3'b000, 3'b000);
        base = wr_cnt;
        pulse_lat(2);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt - base >= 40) break;
        end
        check("write 40 reached", wr_cnt - base, 40);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid reset mem_we", int'(mem_we), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset writes", wr_cnt - base, 40);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bbase = busy_cnt;
        repeat (300) @(negedge clk);
        #1;
        check("no writes after abort", wr_cnt - base, 40);
        check("idle after abort", busy_cnt - bbase, 0);

        base = wr_cnt;
        shift_line(W, 3'b100, 3'b000, 3'b000, 3'b000);
        pulse_lat(4);
        wait_commit();
        check("post-reset writes", wr_cnt - base, 2 * W);
        check("post-reset first addr", int'(log_addr[base]), 4 * W);
        check("post-reset last addr", int'(log_addr[base + 2 * W - 1]), 20 * W + W - 1);
        check("post-reset data x95", int'(log_data[base + W - 1]), 32'h0000_0F00);
        check("post-reset len_err", int'(len_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
